lpc_capture: RTL

LPC_CAPTURE -- requirements
Module: lpc_capture

---
 rtl/lpc_capture.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lpc_capture.sv
// lpc_capture: passive LPC I/O-cycle snooper that reports completed cycles whose address falls in [ADDR_LO, ADDR_HI].
// Reads are always captured; define LPC_CAPTURE_WRITE_EN to capture I/O writes as well.
module lpc_capture #(
  parameter logic [3:0]  START_NIBBLE = 4'h5,
  parameter logic [15:0] ADDR_LO      = 16'h0024,
  parameter logic [15:0] ADDR_HI      = 16'h0027,
  parameter int unsigned SYNC_TIMEOUT = 8
) (
  input  logic        lpc_clk,
  input  logic        reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic        out_valid,
  output logic [3:0]  out_cyctype_dir,
  output logic [15:0] out_addr,
  output logic [7:0]  out_data,
  output logic        out_sync_timeout,
  output logic        out_abort
);

  typedef enum logic [3:0] {
    S_IDLE, S_CYCTYPE, S_ADDR, S_WDATA1, S_WDATA2, S_TAR1,
    S_TAR2, S_SYNC, S_RDATA1, S_RDATA2, S_TAREND1, S_TAREND2
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(SYNC_TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  nib_cnt;
  logic [7:0]  wait_cnt;
  logic [3:0]  cyc_sh;
  logic [15:0] addr_sh;
  logic [7:0]  data_sh;
  logic        valid_d, abort_d, timeout_d;

  logic        start_hit, sync_ready, sync_error, wait_expired;
  logic        addr_in_window, write_path, cyc_accept;
  logic [15:0] addr_full;

  assign start_hit      = !lpc_frame && (lpc_ad == START_NIBBLE);
  assign sync_ready     = (lpc_ad == 4'b0000);
  assign sync_error     = (lpc_ad == 4'b1010);
  assign wait_expired   = ((wait_cnt + 8'd1) == TMO_LIMIT);
  // The window test needs the nibble arriving this clock, not the shadow alone.
  assign addr_full      = {addr_sh[11:0], lpc_ad};
  assign addr_in_window = (addr_full >= ADDR_LO) && (addr_full <= ADDR_HI);

`ifdef LPC_CAPTURE_WRITE_EN
  assign write_path = cyc_sh[1];
  assign cyc_accept = (lpc_ad[3:2] == 2'b00);
`else
  assign write_path = 1'b0;
  assign cyc_accept = (lpc_ad[3:1] == 3'b000);
`endif

  always_ff @(posedge lpc_clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    if (!lpc_frame) begin
      state_d = start_hit ? S_CYCTYPE : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_CYCTYPE: state_d = cyc_accept ? S_ADDR : S_IDLE;
        S_ADDR: begin
          if (nib_cnt == 2'd3) begin
            if (!addr_in_window) state_d = S_IDLE;
            else                 state_d = write_path ? S_WDATA1 : S_TAR1;
          end
        end
        S_WDATA1:  state_d = S_WDATA2;
        S_WDATA2:  state_d = S_TAR1;
        S_TAR1:    state_d = S_TAR2;
        S_TAR2:    state_d = S_SYNC;
        S_SYNC: begin
          if (sync_ready)                      state_d = write_path ? S_TAREND1 : S_RDATA1;
          else if (sync_error || wait_expired) state_d = S_IDLE;
        end
        S_RDATA1:  state_d = S_RDATA2;
        S_RDATA2:  state_d = S_TAREND1;
        S_TAREND1: state_d = S_TAREND2;
        S_TAREND2: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Pulse requests are mutually exclusive by construction; they are registered below.
  always_comb begin
    valid_d   = 1'b0;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    if (!lpc_frame) begin
      abort_d = !start_hit && (state_q != S_IDLE) && (state_q != S_CYCTYPE);
    end else if (state_q == S_TAREND2) begin
      valid_d = 1'b1;
    end else if ((state_q == S_SYNC) && !sync_ready) begin
      if (sync_error) abort_d   = 1'b1;
      else            timeout_d = wait_expired;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (reset) begin
      nib_cnt          <= '0;
      wait_cnt         <= '0;
      cyc_sh           <= '0;
      addr_sh          <= '0;
      data_sh          <= '0;
      out_valid        <= 1'b0;
      out_abort        <= 1'b0;
      out_sync_timeout <= 1'b0;
      out_cyctype_dir  <= '0;
      out_addr         <= '0;
      out_data         <= '0;
    end else begin
      out_valid        <= valid_d;
      out_abort        <= abort_d;
      out_sync_timeout <= timeout_d;
      if (start_hit) begin
        nib_cnt  <= '0;
        wait_cnt <= '0;
      end else if (lpc_frame) begin
        case (state_q)
          S_CYCTYPE: cyc_sh <= lpc_ad;
          S_ADDR: begin
            addr_sh <= addr_full;
            nib_cnt <= nib_cnt + 2'd1;
          end
          S_WDATA1, S_RDATA1: data_sh[3:0] <= lpc_ad;
          S_WDATA2, S_RDATA2: data_sh[7:4] <= lpc_ad;
          S_SYNC: if (!sync_ready && !sync_error) wait_cnt <= wait_cnt + 8'd1;
          S_TAREND2: begin
            out_cyctype_dir <= cyc_sh;
            out_addr        <= addr_sh;
            out_data        <= data_sh;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
